s3g_tx_pp: RTL and testbench



---
 rtl/s3g_pkg.sv | 29 ++
 rtl/s3g_pp_buf.sv | 88 ++++++++
 rtl/s3g_tx_pp.sv | 175 +++++++++++++++++
 tb/tb_s3g_tx_pp.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s3g_pkg.sv
// Shared definitions for the S3G packet transmitter: sync byte, framing
// states and the CRC-8 byte update (polynomial x^8 + x^2 + x + 1, MSB first).
package s3g_pkg;

    localparam logic [7:0] S3G_SYNC  = 8'hD5;
    localparam logic [7:0] CRC8_POLY = 8'h07;

    // Framing states; the encoding fills the 2-bit space.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2,
        S_CRC  = 2'd3
    } state_t;

    // One byte of CRC-8 update, data processed MSB first, no reflection.
    function automatic logic [7:0] nextCRC8_D8(input logic [7:0] data,
                                               input logic [7:0] crc);
        logic [7:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ data[i];
            c  = {c[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
        end
        return c;
    endfunction

endpackage

// File: rtl/s3g_pp_buf.sv
// Two-bank payload store. One bank belongs to the host (loading), the other
// to the transmitter (reading). A commit marks the host bank pending; the
// framer's launch pulse swaps ownership and frees the host side again.
//
// Handshake: ld_ready=1 means the host bank may be written and committed.
// A commit is accepted only in a cycle with packet_wr=1, ld_ready=1 and a
// legal length; ld_ready drops the following cycle and rises again only
// when the framer launches the committed bank.
module s3g_pp_buf
    import s3g_pkg::*;
#(
    parameter int MAX_PAYLOAD = 32,
    parameter int ADDR_W      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    input  logic [7:0]        payload_len,
    input  logic              len_ok,
    input  logic              packet_wr,
    input  logic              launch,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic [7:0]        tx_len,
    output logic              pending,
    output logic              ld_ready,
    output logic              err_ovf
);

    logic [7:0] mem [2][MAX_PAYLOAD];
    logic [7:0] len_q [2];
    logic       hbank;
    logic       tbank;
    logic       addr_ok;
    logic       commit;

    // Out-of-range write addresses are dropped rather than aliased.
    assign addr_ok = (32'(ld_addr) < MAX_PAYLOAD);
    assign commit  = packet_wr && ld_ready && len_ok;

    // Host byte writes into the host-owned bank; contents are never reset.
    always_ff @(posedge clk) begin
        if (ld_we && addr_ok) begin
            mem[hbank][ld_addr] <= ld_data;
        end
    end

    // Per-bank length, captured only by an accepted commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q[0] <= 8'h00;
            len_q[1] <= 8'h00;
        end else if (commit) begin
            len_q[hbank] <= payload_len;
        end
    end

    // Bank ownership, pending flag, ready flag and overflow pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hbank    <= 1'b0;
            tbank    <= 1'b0;
            pending  <= 1'b0;
            ld_ready <= 1'b1;
            err_ovf  <= 1'b0;
        end else begin
            err_ovf <= packet_wr && !ld_ready;
            // launch needs pending=1 and commit needs ld_ready=1; the two
            // are never true together, so the order here is not a priority.
            if (launch) begin
                tbank    <= hbank;
                hbank    <= ~hbank;
                pending  <= 1'b0;
                ld_ready <= 1'b1;
            end else if (commit) begin
                pending  <= 1'b1;
                ld_ready <= 1'b0;
            end
        end
    end

    // Combinational read of the transmit bank.
    assign rd_data = mem[tbank][rd_addr];
    assign tx_len  = len_q[tbank];

endmodule

// File: rtl/s3g_tx_pp.sv
// S3G packet transmitter top: frames each committed payload as
// D5, length, payload bytes, CRC-8 onto a byte link.
//
// Link handshake: tx_wr is a one-cycle strobe qualifying tx_data; the next
// byte is offered only after tx_done, and tx_done is ignored while tx_wr is
// high and while idle, so tx_wr never stays high two cycles in a row.
module s3g_tx_pp
    import s3g_pkg::*;
#(
    parameter int MAX_PAYLOAD = 32,
    parameter int ADDR_W      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    input  logic [7:0]        payload_len,
    input  logic              packet_wr,
    output logic              ld_ready,
    input  logic              abort,
    output logic [7:0]        tx_data,
    output logic              tx_wr,
    input  logic              tx_done,
    output logic              busy,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic              err_len,
    output logic              err_ovf
);

    state_t     state;
    state_t     next_state;
    logic [7:0] idx;
    logic [7:0] crc;
    logic [7:0] rd_data;
    logic [7:0] tx_len;
    logic       pending;
    logic       len_ok;
    logic       done_ok;

    // Decoded actions for the current cycle.
    logic       launch;
    logic       send_hdr;
    logic       send_byte;
    logic       send_crc;
    logic       finish;
    logic       drop;

    assign len_ok  = (payload_len <= 8'(MAX_PAYLOAD));
    assign done_ok = tx_done && !tx_wr;

    s3g_pp_buf #(
        .MAX_PAYLOAD (MAX_PAYLOAD),
        .ADDR_W      (ADDR_W)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .ld_we       (ld_we),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .payload_len (payload_len),
        .len_ok      (len_ok),
        .packet_wr   (packet_wr),
        .launch      (launch),
        .rd_addr     (idx[ADDR_W-1:0]),
        .rd_data     (rd_data),
        .tx_len      (tx_len),
        .pending     (pending),
        .ld_ready    (ld_ready),
        .err_ovf     (err_ovf)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection from the decoded actions.
    always_comb begin
        next_state = state;
        if (launch) begin
            next_state = S_HDR;
        end else if (send_hdr) begin
            next_state = S_DATA;
        end else if (send_crc) begin
            next_state = S_CRC;
        end else if (finish || drop) begin
            next_state = S_IDLE;
        end
    end

    // Action decode; abort outranks tx_done in every busy state.
    always_comb begin
        launch    = 1'b0;
        send_hdr  = 1'b0;
        send_byte = 1'b0;
        send_crc  = 1'b0;
        finish    = 1'b0;
        drop      = 1'b0;
        case (state)
            S_IDLE: launch = pending;
            S_HDR: begin
                if (abort)        drop     = 1'b1;
                else if (done_ok) send_hdr = 1'b1;
            end
            S_DATA: begin
                if (abort) begin
                    drop = 1'b1;
                end else if (done_ok) begin
                    if (idx != tx_len) send_byte = 1'b1;
                    else               send_crc  = 1'b1;
                end
            end
            S_CRC: begin
                if (abort)        drop   = 1'b1;
                else if (done_ok) finish = 1'b1;
            end
            default: drop = 1'b1;
        endcase
    end

    // Link byte, payload index, running CRC, busy flag and packet counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data <= 8'h00;
            tx_wr   <= 1'b0;
            busy    <= 1'b0;
            idx     <= 8'h00;
            crc     <= 8'h00;
            pkt_cnt <= '0;
        end else begin
            tx_wr <= launch || send_hdr || send_byte || send_crc;
            if (launch) begin
                tx_data <= S3G_SYNC;
                busy    <= 1'b1;
            end
            if (send_hdr) begin
                tx_data <= tx_len;
                idx     <= 8'h00;
                crc     <= 8'h00;
            end
            if (send_byte) begin
                tx_data <= rd_data;
                crc     <= nextCRC8_D8(rd_data, crc);
                idx     <= idx + 8'd1;
            end
            if (send_crc) begin
                tx_data <= crc;
            end
            if (finish) begin
                busy    <= 1'b0;
                pkt_cnt <= pkt_cnt + CNT_W'(1);
            end
            if (drop) begin
                busy <= 1'b0;
            end
        end
    end

    // Length rejection pulse; an unavailable bank is reported as overflow
    // instead, so a bad length only counts when the host bank was free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_len <= 1'b0;
        end else begin
            err_len <= packet_wr && ld_ready && !len_ok;
        end
    end

endmodule

// File: tb/tb_s3g_tx_pp.sv
// Bench for s3g_tx_pp: a link responder checks every byte against frames
// predicted from committed payloads (sync, length, bytes, CRC-8).
module tb_s3g_tx_pp;

    localparam int         MAX  = 32;
    localparam int         AW   = 5;
    localparam int         CW   = 16;
    localparam logic [7:0] SYNC = 8'hD5;

    logic          clk;
    logic          rst_n;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_data;
    logic [7:0]    payload_len;
    logic          packet_wr;
    logic          ld_ready;
    logic          abort;
    logic [7:0]    tx_data;
    logic          tx_wr;
    logic          tx_done;
    logic          busy;
    logic [CW-1:0] pkt_cnt;
    logic          err_len;
    logic          err_ovf;

    int         n_checks;
    int         n_fail;
    logic [7:0] exp_q[$];
    logic [7:0] pl[$];
    int         exp_cnt;
    int         link_gap;
    int         rx_cnt;
    logic       prev_wr;

    s3g_tx_pp #(
        .MAX_PAYLOAD (MAX),
        .ADDR_W      (AW),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ld_we       (ld_we),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .payload_len (payload_len),
        .packet_wr   (packet_wr),
        .ld_ready    (ld_ready),
        .abort       (abort),
        .tx_data     (tx_data),
        .tx_wr       (tx_wr),
        .tx_done     (tx_done),
        .busy        (busy),
        .pkt_cnt     (pkt_cnt),
        .err_len     (err_len),
        .err_ovf     (err_ovf)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // CRC-8 poly 0x07 as long division: fold byte in, then shift out 8 bits.
    function automatic logic [7:0] crc_model(input logic [7:0] d[$]);
        logic [7:0] c;
        c = 8'h00;
        foreach (d[i]) begin
            c = c ^ d[i];
            for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    // Link responder and byte scoreboard.
    initial begin
        int cnt;
        cnt = 0;
        tx_done = 1'b0;
        prev_wr = 1'b0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (!rst_n) begin
                cnt = 0;
                prev_wr = 1'b0;
            end else begin
                if (tx_wr) begin
                    check("wr_gap", 32'(prev_wr), 0);
                    rx_cnt++;
                    if (exp_q.size() == 0) check("unexp_wr", 32'(tx_wr), 0);
                    else check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                    cnt = link_gap;
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) tx_done = 1'b1;
                end
                prev_wr = tx_wr;
            end
        end
    end

    task automatic load(input int len, input bit counting);
        pl.delete();
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            ld_we   = 1'b1;
            ld_addr = AW'(i);
            ld_data = counting ? 8'(i + 1) : 8'($urandom_range(0, 255));
            pl.push_back(ld_data);
        end
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    task automatic commit(input int len, input bit ok, input bit e_len, input bit e_ovf,
                          input bit rdy_after);
        @(negedge clk);
        payload_len = 8'(len);
        packet_wr   = 1'b1;
        @(negedge clk);
        packet_wr = 1'b0;
        if (ok) begin
            exp_q.push_back(SYNC);
            exp_q.push_back(8'(len));
            foreach (pl[i]) exp_q.push_back(pl[i]);
            exp_q.push_back(crc_model(pl));
            exp_cnt++;
        end
        check("err_len", 32'(err_len), 32'(e_len));
        check("err_ovf", 32'(err_ovf), 32'(e_ovf));
        check("ld_ready_commit", 32'(ld_ready), 32'(rdy_after));
        @(negedge clk);
        check("err_len_pulse", 32'(err_len), 0);
        check("err_ovf_pulse", 32'(err_ovf), 0);
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_timeout"}, 32'(t < 3000), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_cnt"}, 32'(pkt_cnt), 32'(exp_cnt[CW-1:0]));
    endtask

    task automatic wait_rx(input int n, input string tag);
        int t;
        t = 0;
        while (rx_cnt < n && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_rx_timeout"}, 32'(t < 1000), 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_tx_wr"}, 32'(tx_wr), 0);
        check({tag, "_tx_data"}, 32'(tx_data), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_pkt_cnt"}, 32'(pkt_cnt), 0);
        check({tag, "_ld_ready"}, 32'(ld_ready), 1);
        check({tag, "_err"}, 32'({err_len, err_ovf}), 0);
    endtask

    // Main sequence
    initial begin
        int t;
        int len;
        n_checks = 0; n_fail = 0; exp_cnt = 0; rx_cnt = 0; link_gap = 2;
        rst_n = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = 8'h00;
        payload_len = 8'h00; packet_wr = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // Directed 01 02 03
        load(3, 1'b1);
        commit(3, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_done("basic");

        // Empty payload: D5, 00, 00
        pl.delete();
        commit(0, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_done("empty");

        // Overlap: B committed while A is on the wire, then a rejected third commit
        link_gap = 3;
        rx_cnt = 0;
        load(4, 1'b0);
        commit(4, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_rx(3, "ovl");
        check("ld_ready_free", 32'(ld_ready), 1);
        load(2, 1'b0);
        commit(2, 1'b1, 1'b0, 1'b0, 1'b0);
        commit(1, 1'b0, 1'b0, 1'b1, 1'b0);
        t = 0;
        while (pkt_cnt != CW'(exp_cnt - 1) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("ovl_a_timeout", 32'(t < 500), 1);
        check("ovl_gap_busy", 32'(busy), 0);
        check("ovl_gap_wr", 32'(tx_wr), 0);
        @(negedge clk);
        check("ovl_b_wr", 32'(tx_wr), 1);
        check("ovl_b_sync", 32'(tx_data), 32'(SYNC));
        check("ovl_b_busy", 32'(busy), 1);
        wait_done("ovl");

        // Length boundary
        link_gap = 1;
        commit(MAX + 1, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        check("badlen_cnt", 32'(pkt_cnt), 32'(exp_cnt[CW-1:0]));
        load(MAX, 1'b0);
        commit(MAX, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_done("maxlen");

        // Abort after second payload byte
        link_gap = 3;
        rx_cnt = 0;
        load(6, 1'b0);
        commit(6, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_rx(4, "abort");
        @(negedge clk);
        abort = 1'b1;
        exp_q.delete();
        exp_cnt--;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 0);
        repeat (30) @(negedge clk);
        check("abort_cnt", 32'(pkt_cnt), 32'(exp_cnt[CW-1:0]));
        check("abort_ld_ready", 32'(ld_ready), 1);
        load(5, 1'b0);
        commit(5, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_done("post_abort");

        // Asynchronous reset in the middle of the payload
        link_gap = 2;
        rx_cnt = 0;
        load(8, 1'b0);
        commit(8, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_rx(5, "arst");
        #3;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("arst");
        exp_q.delete();
        exp_cnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load(7, 1'b0);
        commit(7, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_done("post_arst");

        // Random packets and link speeds
        for (int n = 0; n < 8; n++) begin
            len = $urandom_range(0, MAX);
            link_gap = $urandom_range(1, 4);
            check("rand_ld_ready", 32'(ld_ready), 1);
            load(len, 1'b0);
            commit(len, 1'b1, 1'b0, 1'b0, 1'b0);
            wait_done("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit
    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
